// File: rtl/servo_cmd_ctrl_if.sv
// Command word from the SPI slave plus the servo controller's PWM and debug outputs.
interface servo_cmd_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [31:0]       data_in;
  logic              data_ready;
  logic [NUM_CH-1:0] pwm_out;
  logic              failsafe;
  logic [7:0]        cmd_count;
  logic [7:0]        err_count;

  modport master (
    output data_in, data_ready,
    input  pwm_out, failsafe, cmd_count, err_count
  );

  modport slave (
    input  data_in, data_ready,
    output pwm_out, failsafe, cmd_count, err_count
  );
endinterface

// File: rtl/servo_cmd_ctrl.sv
// Servo command decoder: CDC capture of SPI words, double-buffered widths,
// shared-frame PWM generation, link watchdog and saturating debug counters.
module servo_cmd_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int DIV_BITS       = 9,
  parameter int FRAME_TICKS    = 2000,
  parameter int MAX_PERIOD     = 2000,
  parameter int TIMEOUT_FRAMES = 50
) (
  input logic             clk,
  input logic             reset,
  servo_cmd_ctrl_if.slave bus
);
  localparam int W_W   = 11;
  localparam int FC_W  = $clog2(FRAME_TICKS);
  localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);
  localparam int CMP_W = (FC_W > W_W) ? FC_W : W_W;
  localparam logic [7:0]      NUM_CH_B  = 8'(NUM_CH);
  localparam logic [W_W-1:0]  MAX_W     = W_W'(MAX_PERIOD);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_TICKS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_FRAMES);
  localparam logic [WD_W-1:0] WD_PRELIM = WD_W'(TIMEOUT_FRAMES - 1);

  logic [2:0]          sync_q;
  logic [18:0]         cmd_word_q;
  logic                cmd_vld_q;
  logic [DIV_BITS-1:0] presc_q;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                failsafe_q, failsafe_d;
  logic [7:0]          cmd_q, cmd_d, err_q, err_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;
  logic [W_W-1:0]      shadow_q [NUM_CH];
  logic [W_W-1:0]      shadow_d [NUM_CH];
  logic [W_W-1:0]      active_q [NUM_CH];
  logic [W_W-1:0]      active_d [NUM_CH];

  logic           rise_s, tick_s, boundary_s, timeout_s, wd_clr_s;
  logic           set_s, stop_s, bad_s;
  logic [7:0]     ch_s;
  logic [W_W-1:0] width_s, clamp_s;
  logic           unused_low_s;

  assign unused_low_s = ^bus.data_in[12:0];
  assign rise_s       = sync_q[1] & ~sync_q[2];
  assign tick_s       = &presc_q;
  assign boundary_s   = tick_s & (frame_cnt_q == FC_LAST);

  // Command decode from the word captured on the synchronized rising edge.
  always_comb begin
    ch_s    = cmd_word_q[18:11];
    width_s = cmd_word_q[10:0];
    clamp_s = (width_s > MAX_W) ? MAX_W : width_s;
    set_s   = 1'b0;
    stop_s  = 1'b0;
    bad_s   = 1'b0;
    if (cmd_vld_q) begin
      if ((ch_s != 8'd0) && (ch_s <= NUM_CH_B)) begin
        set_s = 1'b1;
      end else if (ch_s == 8'hFF) begin
        stop_s = 1'b1;
      end else if (ch_s != 8'd0) begin
        bad_s = 1'b1;
      end else begin
        bad_s = 1'b0;
      end
    end else begin
      set_s = 1'b0;
    end
  end

  // Timebase, watchdog, counters and failsafe next state.
  always_comb begin
    wd_clr_s  = set_s | stop_s;
    timeout_s = boundary_s & ~wd_clr_s & (wd_q == WD_PRELIM);
    if (!tick_s) begin
      frame_cnt_d = frame_cnt_q;
    end else if (boundary_s) begin
      frame_cnt_d = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end
    if (wd_clr_s) begin
      wd_d = '0;
    end else if (boundary_s && (wd_q != WD_LIMIT)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
    if (set_s) begin
      failsafe_d = 1'b0;
    end else if (timeout_s) begin
      failsafe_d = 1'b1;
    end else begin
      failsafe_d = failsafe_q;
    end
    cmd_d = (wd_clr_s && (cmd_q != 8'hFF)) ? cmd_q + 8'd1 : cmd_q;
    err_d = (bad_s && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // Active widths load the pre-write shadow on a frame boundary; timeout wipes both.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (timeout_s) begin
        shadow_d[i] = '0;
        active_d[i] = '0;
      end else begin
        active_d[i] = boundary_s ? shadow_q[i] : active_q[i];
        if (stop_s) begin
          shadow_d[i] = '0;
        end else if (set_s && (ch_s == 8'(i + 1))) begin
          shadow_d[i] = clamp_s;
        end else begin
          shadow_d[i] = shadow_q[i];
        end
      end
      pwm_d[i] = ~failsafe_q & (CMP_W'(frame_cnt_q) < CMP_W'(active_q[i]));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 3'b000;
      cmd_word_q  <= '0;
      cmd_vld_q   <= 1'b0;
      presc_q     <= '0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
      failsafe_q  <= 1'b1;
      cmd_q       <= 8'd0;
      err_q       <= 8'd0;
      pwm_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      sync_q      <= {sync_q[1:0], bus.data_ready};
      cmd_word_q  <= rise_s ? bus.data_in[31:13] : cmd_word_q;
      cmd_vld_q   <= rise_s;
      presc_q     <= presc_q + DIV_BITS'(1);
      frame_cnt_q <= frame_cnt_d;
      wd_q        <= wd_d;
      failsafe_q  <= failsafe_d;
      cmd_q       <= cmd_d;
      err_q       <= err_d;
      pwm_q       <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign bus.pwm_out   = pwm_q;
  assign bus.failsafe  = failsafe_q;
  assign bus.cmd_count = cmd_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Random and directed command stimulus checked every cycle against a frame-arithmetic model.
module tb_servo_cmd_ctrl;
  localparam int NCH = 4;
  localparam int DB  = 2;
  localparam int P   = 4;
  localparam int FT  = 50;
  localparam int MP  = 50;
  localparam int TO  = 6;
  localparam int F   = P * FT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  servo_cmd_ctrl_if #(.NUM_CH(NCH)) bus ();

  servo_cmd_ctrl #(
    .NUM_CH(NCH), .DIV_BITS(DB), .FRAME_TICKS(FT), .MAX_PERIOD(MP), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the frame position is derived from the cycle index alone.
  int m_shadow [NCH];
  int m_active [NCH];
  int m_nact [NCH];
  bit m_fs;
  int m_wd, m_cmd, m_err;
  logic [NCH-1:0] m_pwm, m_npwm;
  int idx, last_idx;
  int q_at[$];
  logic [31:0] q_w[$];
  int m_fc, m_ch, m_wid;
  bit m_bnd, m_clr;
  logic [31:0] m_word;
  int hi_cnt [NCH];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      m_fs = 1'b1; m_wd = 0; m_cmd = 0; m_err = 0; m_pwm = '0;
      idx = 0; last_idx = -1;
    end else begin
      m_fc  = (idx / P) % FT;
      m_bnd = ((idx + 1) % F) == 0;
      for (int i = 0; i < NCH; i++) begin
        m_npwm[i] = !m_fs && (m_fc < m_active[i]);
        m_nact[i] = m_bnd ? m_shadow[i] : m_active[i];
      end
      m_clr = 1'b0;
      if (q_at.size() > 0 && q_at[0] == idx) begin
        void'(q_at.pop_front());
        m_word = q_w.pop_front();
        m_ch   = int'(m_word[31:24]);
        m_wid  = int'(m_word[23:13]);
        if (m_ch >= 1 && m_ch <= NCH) begin
          m_shadow[m_ch-1] = (m_wid > MP) ? MP : m_wid;
          if (m_cmd < 255) m_cmd++;
          m_wd = 0; m_fs = 1'b0; m_clr = 1'b1;
        end else if (m_ch == 255) begin
          for (int i = 0; i < NCH; i++) m_shadow[i] = 0;
          if (m_cmd < 255) m_cmd++;
          m_wd = 0; m_clr = 1'b1;
        end else if (m_ch != 0) begin
          if (m_err < 255) m_err++;
        end
      end
      if (m_bnd && !m_clr && m_wd < TO) begin
        m_wd++;
        if (m_wd == TO) begin
          m_fs = 1'b1;
          for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_nact[i] = 0; end
        end
      end
      for (int i = 0; i < NCH; i++) m_active[i] = m_nact[i];
      m_pwm = m_npwm;
      last_idx = idx;
      idx++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check_eq("pwm_out", 32'(bus.pwm_out), 32'(m_pwm));
      check_eq("failsafe", 32'(bus.failsafe), 32'(m_fs));
      check_eq("cmd_count", 32'(bus.cmd_count), 32'(m_cmd));
      check_eq("err_count", 32'(bus.err_count), 32'(m_err));
    end
  end

  task automatic drive_word(input logic [31:0] w);
    bus.data_in = w;
    bus.data_ready = 1'b1;
    q_at.push_back(last_idx + 4);
    q_w.push_back(w);
    repeat (6) @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    drive_word(w);
  endtask

  task automatic send_at(input logic [31:0] w, input int apply_idx);
    int guard = 0;
    while (last_idx < apply_idx - 4 && guard < 5000) begin @(negedge clk); guard++; end
    check_eq("send_align", 32'(last_idx), 32'(apply_idx - 4));
    drive_word(w);
  endtask

  task automatic frame_high();
    int guard = 0;
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    @(negedge clk);
    while ((last_idx % F) != F - 1 && guard < 2 * F) begin @(negedge clk); guard++; end
    check_eq("frame_sync", 32'(last_idx % F), 32'(F - 1));
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (bus.pwm_out[c]) hi_cnt[c]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.data_ready = 1'b0;
    q_at.delete();
    q_w.delete();
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check_eq("rst_failsafe", 32'(bus.failsafe), 32'd1);
    check_eq("rst_cmd", 32'(bus.cmd_count), 32'd0);
    check_eq("rst_err", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ch;
    logic [10:0] wid;
    int sel, b;
    bus.data_in = 32'd0;
    bus.data_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);

    send({8'd1, 11'd17, 13'h0ABC});
    check_eq("fs_drop", 32'(bus.failsafe), 32'd0);
    frame_high();
    check_eq("ch1_hi", 32'(hi_cnt[0]), 32'(17 * P));

    send({8'd2, 11'd2047, 13'h1FFF});
    frame_high();
    check_eq("ch2_clamp_hi", 32'(hi_cnt[1]), 32'(F));
    check_eq("ch1_hold", 32'(hi_cnt[0]), 32'(17 * P));

    b = ((last_idx + 10) / F + 1) * F - 1;
    fork
      send_at({8'd2, 11'd10, 13'h0000}, b);
      frame_high();
    join
    check_eq("bnd_old_width", 32'(hi_cnt[1]), 32'(F));
    frame_high();
    check_eq("bnd_new_width", 32'(hi_cnt[1]), 32'(10 * P));

    send({8'd7, 11'd33, 13'h0000});
    send({8'd0, 11'd44, 13'h0000});
    check_eq("bad_err", 32'(bus.err_count), 32'd1);
    check_eq("bad_cmd", 32'(bus.cmd_count), 32'd3);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      ch  = (sel < 6) ? 8'($urandom_range(1, NCH)) : (sel == 6) ? 8'd0 :
            (sel == 7) ? 8'hFF : 8'($urandom_range(5, 254));
      wid = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 60));
      send({ch, wid, 13'($urandom)});
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end

    send({8'd1, 11'd20, 13'h0000});
    send({8'd3, 11'd30, 13'h0000});
    frame_high();
    check_eq("run_ch1", 32'(hi_cnt[0]), 32'(20 * P));
    send({8'hFF, 11'd99, 13'h0000});
    frame_high();
    check_eq("stop_ch1", 32'(hi_cnt[0]), 32'd0);
    check_eq("stop_ch3", 32'(hi_cnt[2]), 32'd0);
    check_eq("stop_fs", 32'(bus.failsafe), 32'd0);

    repeat ((TO + 1) * F) @(negedge clk);
    check_eq("wd_fs", 32'(bus.failsafe), 32'd1);
    check_eq("wd_pwm", 32'(bus.pwm_out), 32'd0);
    send({8'd3, 11'd5, 13'h0000});
    check_eq("wd_fs_clear", 32'(bus.failsafe), 32'd0);
    frame_high();
    check_eq("wd_ch3", 32'(hi_cnt[2]), 32'(5 * P));
    check_eq("wd_others", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[3]), 32'd0);

    for (int k = 0; k < 260; k++) send({8'h80, 11'd0, 13'h0000});
    check_eq("err_sat", 32'(bus.err_count), 32'd255);

    @(negedge clk);
    bus.data_in = {8'd1, 11'd25, 13'h0000};
    bus.data_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    check_eq("midrst_cmd", 32'(bus.cmd_count), 32'd0);
    check_eq("midrst_fs", 32'(bus.failsafe), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
